// File: rtl/serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl
//
// Bit-serial add/subtract sequencer that drives one shared, external
// full_adder cell. It latches two WIDTH-bit operands, then presents one bit
// pair per clock to the cell, LSB first. It registers the carry between bits
// and assembles the sum from the cell's sum output.
//
// Handshake: the requester raises `start` with `sub`, `a` and `b` valid. The
// block accepts the request on any rising edge where it is IDLE and `start`
// is high. While `busy` is high, `start` is ignored and nothing is queued.
// `done` pulses for one cycle, and `result`, `cout` and `ovf` are valid from
// that cycle. They hold until the next accepted request completes.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, sub      request and operation select (0 = a+b, 1 = a-b)
//   a, b            operands, sampled on the accepting edge
//   busy            high in RUN and DONE
//   done            one-cycle completion pulse
//   result          WIDTH-bit sum/difference (modulo 2^WIDTH)
//   cout            final carry out (for subtract: 1 = no borrow)
//   ovf             signed two's-complement overflow
//   fa_a/fa_b/fa_ci bit operands and carry-in to the full_adder (0 outside RUN)
//   fa_s/fa_co      sum and carry-out from the full_adder
// -----------------------------------------------------------------------------
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic accept;
    logic last_bit;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (count == LAST_BIT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the cell sees live bits only in RUN, zeros otherwise
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        fa_a  = 1'b0;
        fa_b  = 1'b0;
        fa_ci = 1'b0;
        case (state)
            RUN: begin
                busy  = 1'b1;
                fa_a  = a_sr[0];
                fa_b  = b_sr[0];
                fa_ci = carry;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath. A subtraction is a + ~b + 1: b is inverted on accept and the
    // initial carry is set to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            carry  <= fa_co;
            count  <= count + 1'b1;
            if (last_bit) begin
                // The MSB comes straight from the cell, so the result does not
                // wait an extra cycle for the shift register.
                result <= {fa_s, sum_sr[WIDTH-1:1]};
                cout   <= fa_co;
                // Overflow: the carry into the MSB differs from the carry out.
                ovf    <= fa_co ^ carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;

  localparam int WIDTH = 8;
  localparam int EW = WIDTH + 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             fa_a;
  logic             fa_b;
  logic             fa_ci;
  logic             fa_s;
  logic             fa_co;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_ci  (fa_ci),
    .fa_s   (fa_s),
    .fa_co  (fa_co)
  );

  // Full-adder cell owned by the bench
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [EW-1:0] pk(input logic [WIDTH-1:0] r, input logic c, input logic o);
    return {r, c, o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp_v);
    end
  endtask

  // Scoreboard monitor: pops one expectation on every done pulse
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'({result, cout, ovf}), 32'(e));
      end
    end
  end

  // Driver: issue one operation from IDLE and check its handshake timing.
  // With disturb set, extra start pulses carrying other operands are applied
  // in cycles 3 and 8 of the run.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic s, input logic [EW-1:0] exp_v, input bit disturb);
    int  n;
    bit  seen;
    @(negedge clk);
    a = av; b = bv; sub = s; start = 1'b1;
    exp_q.push_back(exp_v);
    @(posedge clk);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      start = disturb && (n == 3 || n == 8);
      if (start) begin
        a = ~av; b = 8'h5A; sub = ~s;
      end
      if (done) seen = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
    if (seen) begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      check({tag, "_fa_at_done"}, 32'({fa_a, fa_b, fa_ci}), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 32'(done), 32'd0);
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    check({tag, "_fa_idle"}, 32'({fa_a, fa_b, fa_ci}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'({result, cout, ovf}), 32'd0);
    check("reset_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed results
    run_op("add_25_17", 8'd25, 8'd17, 1'b0, pk(8'h2A, 1'b0, 1'b0), 0);
    run_op("add_100_100", 8'd100, 8'd100, 1'b0, pk(8'hC8, 1'b0, 1'b1), 0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, pk(8'h00, 1'b1, 1'b0), 0);
    run_op("sub_5_7", 8'd5, 8'd7, 1'b1, pk(8'hFE, 1'b0, 1'b0), 0);
    run_op("ignore_start", 8'h12, 8'h34, 1'b0, pk(8'h46, 1'b0, 1'b0), 1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, pk(8'h7F, 1'b1, 1'b1), 0);

    // Reset during RUN cycle 4: aborted, no done, outputs cleared at once
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_outputs", 32'({result, cout, ovf}), 32'd0);
    check("midrun_rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("sub_50_30_after_rst", 8'h50, 8'h30, 1'b1, pk(8'h20, 1'b1, 1'b0), 0);

    // start held high for three back-to-back operations
    @(negedge clk);
    a = 8'h33; b = 8'h44; sub = 1'b0; start = 1'b1;
    exp_q.push_back(pk(8'h77, 1'b0, 1'b0));
    exp_q.push_back(pk(8'hF0, 1'b0, 1'b0));
    exp_q.push_back(pk(8'h80, 1'b0, 1'b1));
    @(posedge clk);
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 8'h10; b = 8'h20; sub = 1'b1;
      end
      if (n == 11) begin
        a = 8'h7F; b = 8'h01; sub = 1'b0;
      end
      if (n == 21) start = 1'b0;
      check($sformatf("held_done_n%0d", n), 32'(done), 32'(n == 9 || n == 19 || n == 29));
      if (n % 10 == 0 || n == 9 || n == 19 || n == 29)
        check($sformatf("held_fa_n%0d", n), 32'({fa_a, fa_b, fa_ci}), 32'd0);
      if (n % 10 == 0)
        check($sformatf("held_busy_n%0d", n), 32'(busy), 32'd0);
    end

    repeat (3) @(negedge clk);
    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
